// File: rtl/uart_program_loader.sv
// uart_program_loader
// Receives a program over an 8N1 UART line and writes it into an instruction
// memory. Stream format: a length byte N (1..DEPTH), then N words of WORD_W/8
// bytes each (MSB first), then an 8-bit modulo-256 sum of all data bytes.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   UART_TXD_IN  asynchronous serial input, idle high
//   wr_en        one-cycle write strobe to instruction memory
//   wr_addr      word address for wr_en
//   wr_data      assembled word for wr_en
//   words_loaded number of words written so far
//   load_done    sticky: program received with valid checksum
//   load_error   sticky: length, framing or checksum error
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_W       = 16,
    parameter int DEPTH        = 32,
    parameter int ADDR_W       = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              UART_TXD_IN,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [7:0]        words_loaded,
    output logic              load_done,
    output logic              load_error
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BPW   = WORD_W / 8;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [1:0]       BYTE_LAST = 2'(BPW - 1);
    localparam logic [7:0]       DEPTH_B   = 8'(DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_LEN, RECV_DATA, RECV_SUM, DONE, ERROR} ld_state_t;

    logic             sync1_r, sync2_r;
    rx_state_t        rx_state_r, rx_state_s;
    logic [CNT_W-1:0] rx_cnt_r;
    logic [2:0]       rx_bit_r;
    logic [7:0]       rx_shift_r;
    logic [7:0]       rx_byte_r;
    logic             byte_valid_r, frame_err_r;
    logic             tick_s;

    ld_state_t        ld_state_r, ld_state_s;
    logic [7:0]       len_r, sum_r;
    logic [WORD_W-1:0] word_r, word_next_s;
    logic [1:0]       byte_cnt_r;
    logic             word_last_s, prog_last_s;
    logic             wr_en_s, load_done_s, load_error_s;

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= UART_TXD_IN;
            sync2_r <= sync1_r;
        end
    end

    // Terminal count of the bit-timing counter for the current receiver phase
    always_comb begin
        tick_s = 1'b0;
        case (rx_state_r)
            RX_START:         tick_s = (rx_cnt_r == HALF_LAST);
            RX_DATA, RX_STOP: tick_s = (rx_cnt_r == BIT_LAST);
            default:          tick_s = 1'b0;
        endcase
    end

    // Receiver state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_state_r <= RX_IDLE;
        end else begin
            rx_state_r <= rx_state_s;
        end
    end

    // Receiver next state; a start bit that is high again at mid-bit is a glitch
    always_comb begin
        rx_state_s = rx_state_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (!sync2_r) rx_state_s = RX_START;
                else          rx_state_s = RX_IDLE;
            end
            RX_START: begin
                if (tick_s) rx_state_s = sync2_r ? RX_IDLE : RX_DATA;
                else        rx_state_s = RX_START;
            end
            RX_DATA: begin
                if (tick_s && (rx_bit_r == 3'd7)) rx_state_s = RX_STOP;
                else                              rx_state_s = RX_DATA;
            end
            RX_STOP: begin
                if (tick_s) rx_state_s = RX_IDLE;
                else        rx_state_s = RX_STOP;
            end
            default: rx_state_s = RX_IDLE;
        endcase
    end

    // Receiver datapath: bit timer, LSB-first shifter, byte/framing strobes
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_cnt_r     <= '0;
            rx_bit_r     <= 3'd0;
            rx_shift_r   <= 8'd0;
            rx_byte_r    <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if ((rx_state_r == RX_IDLE) || tick_s) rx_cnt_r <= '0;
            else                                   rx_cnt_r <= rx_cnt_r + 1'b1;
            if (rx_state_r == RX_START) rx_bit_r <= 3'd0;
            if ((rx_state_r == RX_DATA) && tick_s) begin
                rx_shift_r <= {sync2_r, rx_shift_r[7:1]};
                rx_bit_r   <= rx_bit_r + 3'd1;
            end
            if ((rx_state_r == RX_STOP) && tick_s) begin
                if (sync2_r) begin
                    byte_valid_r <= 1'b1;
                    rx_byte_r    <= rx_shift_r;
                end else begin
                    frame_err_r <= 1'b1;
                end
            end
        end
    end

    // Word assembly helpers: MSB-first shift-in and end-of-word/program detect
    always_comb begin
        word_next_s = (word_r << 8) | WORD_W'(rx_byte_r);
        word_last_s = byte_valid_r && (byte_cnt_r == BYTE_LAST);
        prog_last_s = word_last_s && ((words_loaded + 8'd1) == len_r);
    end

    // Loader state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_state_r <= WAIT_LEN;
        end else begin
            ld_state_r <= ld_state_s;
        end
    end

    // Loader next state; DONE and ERROR only leave through reset
    always_comb begin
        ld_state_s = ld_state_r;
        case (ld_state_r)
            WAIT_LEN: begin
                if (frame_err_r) ld_state_s = ERROR;
                else if (byte_valid_r) begin
                    if ((rx_byte_r == 8'd0) || (rx_byte_r > DEPTH_B)) ld_state_s = ERROR;
                    else                                             ld_state_s = RECV_DATA;
                end else ld_state_s = WAIT_LEN;
            end
            RECV_DATA: begin
                if (frame_err_r)      ld_state_s = ERROR;
                else if (prog_last_s) ld_state_s = RECV_SUM;
                else                  ld_state_s = RECV_DATA;
            end
            RECV_SUM: begin
                if (frame_err_r)       ld_state_s = ERROR;
                else if (byte_valid_r) ld_state_s = (rx_byte_r == sum_r) ? DONE : ERROR;
                else                   ld_state_s = RECV_SUM;
            end
            DONE:    ld_state_s = DONE;
            ERROR:   ld_state_s = ERROR;
            default: ld_state_s = ERROR;
        endcase
    end

    // Loader outputs (next values); flags follow the absorbing states
    always_comb begin
        wr_en_s      = (ld_state_r == RECV_DATA) && word_last_s;
        load_done_s  = (ld_state_s == DONE);
        load_error_s = (ld_state_s == ERROR);
    end

    // Registered outputs plus length, checksum and partial-word registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= 8'd0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            len_r        <= 8'd0;
            sum_r        <= 8'd0;
            word_r       <= '0;
            byte_cnt_r   <= 2'd0;
        end else begin
            wr_en      <= wr_en_s;
            load_done  <= load_done_s;
            load_error <= load_error_s;
            if (wr_en_s) begin
                wr_addr      <= words_loaded[ADDR_W-1:0];
                wr_data      <= word_next_s;
                words_loaded <= words_loaded + 8'd1;
            end
            case (ld_state_r)
                WAIT_LEN: begin
                    if (byte_valid_r) begin
                        len_r      <= rx_byte_r;
                        sum_r      <= 8'd0;
                        word_r     <= '0;
                        byte_cnt_r <= 2'd0;
                    end
                end
                RECV_DATA: begin
                    if (byte_valid_r) begin
                        sum_r      <= sum_r + rx_byte_r;
                        word_r     <= word_next_s;
                        byte_cnt_r <= word_last_s ? 2'd0 : (byte_cnt_r + 2'd1);
                    end
                end
                default: len_r <= len_r;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader (CLKS_PER_BIT=4, WORD_W=16, DEPTH=32).
// Expected writes are queued as bytes are sent; a monitor pops and compares
// each wr_en pulse. Checksums are the modulo-256 sum of the data bytes.
module tb_uart_program_loader;
    localparam int CPB = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        UART_TXD_IN = 1'b1;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  words_loaded;
    logic        load_done;
    logic        load_error;

    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB), .WORD_W(16), .DEPTH(32), .ADDR_W(5)
    ) dut (
        .CLK(CLK), .RST(RST), .UART_TXD_IN(UART_TXD_IN),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .words_loaded(words_loaded), .load_done(load_done), .load_error(load_error)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every write pulse must match the oldest expected write
    always @(negedge CLK) begin
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0h data=%0h, expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== {e.addr, e.data}) begin
                    errors++;
                    $display("FAIL write got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        UART_TXD_IN = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            UART_TXD_IN = b[i];
            wait_clk(CPB);
        end
        UART_TXD_IN = stop_bit;
        wait_clk(CPB);
        UART_TXD_IN = 1'b1;
        wait_clk(CPB);
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Hold reset and require every output to be zero while it is applied
    task automatic test_reset();
        RST = 1'b1;
        UART_TXD_IN = 1'b1;
        exp_q.delete();
        repeat (2) begin
            @(posedge CLK);
            @(negedge CLK);
            checks++;
            if ({wr_en, wr_addr, wr_data, words_loaded, load_done, load_error} !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs got en=%b addr=%0h data=%0h cnt=%0d done=%b err=%b, expected all 0",
                         wr_en, wr_addr, wr_data, words_loaded, load_done, load_error);
            end
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        wait_clk(4);
    endtask

    // Two-word program with valid checksum (0x12+0x34+0xAB+0xCD = 0x1BE -> 0xBE)
    task automatic test_good_program();
        push_wr(5'd0, 16'h1234);
        push_wr(5'd1, 16'hABCD);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hBE, 1'b1);
        wait_clk(4);
        checks++;
        if ({load_done, load_error, words_loaded} !== {1'b1, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL good_flags got done=%b err=%b cnt=%0d, expected done=1 err=0 cnt=2",
                     load_done, load_error, words_loaded);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL good_writes got %0d writes missing, expected 0", exp_q.size());
        end
        // DONE absorbs further traffic
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        wait_clk(4);
        checks++;
        if ({load_done, load_error, words_loaded} !== {1'b1, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL done_absorb got done=%b err=%b cnt=%0d, expected done=1 err=0 cnt=2",
                     load_done, load_error, words_loaded);
        end
    endtask

    task automatic test_bad_checksum();
        push_wr(5'd0, 16'h1234);
        push_wr(5'd1, 16'hABCD);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        send_byte(8'h71, 1'b1);
        wait_clk(4);
        checks++;
        if ({load_done, load_error, words_loaded} !== {1'b0, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL badsum_flags got done=%b err=%b cnt=%0d, expected done=0 err=1 cnt=2",
                     load_done, load_error, words_loaded);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL badsum_writes got %0d writes missing, expected 0", exp_q.size());
        end
    endtask

    task automatic test_bad_length(input logic [7:0] len);
        send_byte(len, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        wait_clk(4);
        checks++;
        if ({load_done, load_error, words_loaded} !== {1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL badlen_%0h got done=%b err=%b cnt=%0d, expected done=0 err=1 cnt=0",
                     len, load_done, load_error, words_loaded);
        end
    endtask

    // Two-cycle low glitch must not produce a byte, then a one-word program
    task automatic test_glitch();
        UART_TXD_IN = 1'b0;
        wait_clk(2);
        UART_TXD_IN = 1'b1;
        wait_clk(12);
        push_wr(5'd0, 16'hBEEF);
        send_byte(8'h01, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hAD, 1'b1);
        wait_clk(4);
        checks++;
        if ({load_done, load_error, words_loaded} !== {1'b1, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL glitch_flags got done=%b err=%b cnt=%0d, expected done=1 err=0 cnt=1",
                     load_done, load_error, words_loaded);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL glitch_writes got %0d writes missing, expected 0", exp_q.size());
        end
    endtask

    // Stop bit of the second data byte low; later valid bytes are ignored
    task automatic test_frame_error();
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        wait_clk(4);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hBE, 1'b1);
        wait_clk(4);
        checks++;
        if ({load_done, load_error, words_loaded} !== {1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL frame_flags got done=%b err=%b cnt=%0d, expected done=0 err=1 cnt=0",
                     load_done, load_error, words_loaded);
        end
    endtask

    // Maximum length: 32 words fill every address
    task automatic test_full_depth();
        logic [7:0] sum;
        logic [7:0] hi, lo;
        sum = 8'd0;
        send_byte(8'd32, 1'b1);
        for (int i = 0; i < 32; i++) begin
            hi = 8'(i * 7 + 3);
            lo = 8'(i) ^ 8'hA5;
            push_wr(5'(i), {hi, lo});
            sum = sum + hi + lo;
            send_byte(hi, 1'b1);
            send_byte(lo, 1'b1);
        end
        send_byte(sum, 1'b1);
        wait_clk(4);
        checks++;
        if ({load_done, load_error, words_loaded} !== {1'b1, 1'b0, 8'd32}) begin
            errors++;
            $display("FAIL depth_flags got done=%b err=%b cnt=%0d, expected done=1 err=0 cnt=32",
                     load_done, load_error, words_loaded);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL depth_writes got %0d writes missing, expected 0", exp_q.size());
        end
    endtask

    // Reset after three bytes discards the partial program
    task automatic test_reset_mid_program();
        push_wr(5'd0, 16'h1234);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        checks++;
        if ({exp_q.size() == 0, words_loaded} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL premid_cnt got cnt=%0d pending=%0d, expected cnt=1 pending=0",
                     words_loaded, exp_q.size());
        end
        test_reset();
        test_good_program();
    endtask

    initial begin
        test_reset();
        test_good_program();
        test_reset();
        test_bad_checksum();
        test_reset();
        test_bad_length(8'h00);
        test_reset();
        test_bad_length(8'h21);
        test_reset();
        test_glitch();
        test_reset();
        test_frame_error();
        test_reset();
        test_full_depth();
        test_reset();
        test_reset_mid_program();
        wait_clk(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
